// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment codes and hex decode shared by the scan driver
package seg7_pkg;

   typedef logic [6:0] seg_t;

   // Active-low, bit order gfedcba
   localparam seg_t SEG_0   = 7'b1000000;
   localparam seg_t SEG_1   = 7'b1111001;
   localparam seg_t SEG_2   = 7'b0100100;
   localparam seg_t SEG_3   = 7'b0110000;
   localparam seg_t SEG_4   = 7'b0011001;
   localparam seg_t SEG_5   = 7'b0010010;
   localparam seg_t SEG_6   = 7'b0000010;
   localparam seg_t SEG_7   = 7'b1111000;
   localparam seg_t SEG_8   = 7'b0000000;
   localparam seg_t SEG_9   = 7'b0010000;
   localparam seg_t SEG_A   = 7'b0001000;
   localparam seg_t SEG_B   = 7'b0000011;
   localparam seg_t SEG_C   = 7'b1000110;
   localparam seg_t SEG_D   = 7'b0100001;
   localparam seg_t SEG_E   = 7'b0000110;
   localparam seg_t SEG_F   = 7'b0001110;
   localparam seg_t SEG_OFF = 7'h7F;

   function automatic seg_t hex2seg(input logic [3:0] hex);
      seg_t seg;
      seg = SEG_OFF;
      case (hex)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
         default: seg = SEG_OFF;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - load bus between control logic and the scan driver
interface seg7_scan_driver_if #(
   parameter int N_DIGITS = 4
);
   logic                  load_i;
   logic [4*N_DIGITS-1:0] digits_i;
   logic [N_DIGITS-1:0]   dp_i;
   logic [N_DIGITS-1:0]   blank_i;
   logic [N_DIGITS-1:0]   blink_i;
   logic                  lz_en_i;
   logic                  pend_o;

   modport master (output load_i, digits_i, dp_i, blank_i, blink_i, lz_en_i, input pend_o);
   modport slave  (input load_i, digits_i, dp_i, blank_i, blink_i, lz_en_i, output pend_o);
endinterface

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational hex to active-low segment decoder
import seg7_pkg::*;

module seg7_hex_decode (
   input  logic [3:0] hex,
   output logic [6:0] seg
);
   assign seg = hex2seg(hex);
endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed common-anode seven-segment scan driver
import seg7_pkg::*;

module seg7_scan_driver #(
   parameter int N_DIGITS     = 4,
   parameter int SCAN_DIV     = 1000,
   parameter int BLANK_CYCLES = 16,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   seg7_scan_driver_if.slave   bus,
   output logic [6:0]          seg_o,
   output logic                dp_o,
   output logic [N_DIGITS-1:0] an_o,
   output logic                frame_o
);
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam int BF_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] idx;
   logic [BF_W-1:0]  fcnt;
   logic             phase;
   logic             cnt_tc, idx_tc, frame_tick;

   logic [4*N_DIGITS-1:0] act_dig, pnd_dig;
   logic [N_DIGITS-1:0]   act_dp, act_blank, act_blink, pnd_dp, pnd_blank, pnd_blink;
   logic                  act_lz, pnd_lz, pend;

   logic [N_DIGITS-1:0] dark, sel;
   logic                zrun;
   logic [3:0]          cur_digit;
   logic [6:0]          dec_seg;

   assign cnt_tc     = (cnt == CNT_W'(SCAN_DIV - 1));
   assign idx_tc     = (idx == IDX_W'(N_DIGITS - 1));
   assign frame_tick = cnt_tc & idx_tc;
   assign bus.pend_o = pend;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         idx   <= '0;
         fcnt  <= '0;
         phase <= 1'b1;
      end else if (cnt_tc) begin
         cnt <= '0;
         idx <= idx_tc ? '0 : idx + 1'b1;
         if (idx_tc) begin
            if (fcnt == BF_W'(BLINK_FRAMES - 1)) begin
               fcnt  <= '0;
               phase <= ~phase;
            end else begin
               fcnt <= fcnt + 1'b1;
            end
         end
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Active buffer only changes on the frame boundary so a frame is never torn
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_dig <= '0;  act_dp <= '0;  act_blank <= '1;  act_blink <= '0;  act_lz <= 1'b0;
         pnd_dig <= '0;  pnd_dp <= '0;  pnd_blank <= '1;  pnd_blink <= '0;  pnd_lz <= 1'b0;
         pend    <= 1'b0;
      end else if (frame_tick) begin
         pend <= 1'b0;
         if (bus.load_i) begin
            act_dig   <= bus.digits_i;
            act_dp    <= bus.dp_i;
            act_blank <= bus.blank_i;
            act_blink <= bus.blink_i;
            act_lz    <= bus.lz_en_i;
         end else if (pend) begin
            act_dig   <= pnd_dig;
            act_dp    <= pnd_dp;
            act_blank <= pnd_blank;
            act_blink <= pnd_blink;
            act_lz    <= pnd_lz;
         end
      end else if (bus.load_i) begin
         pnd_dig   <= bus.digits_i;
         pnd_dp    <= bus.dp_i;
         pnd_blank <= bus.blank_i;
         pnd_blink <= bus.blink_i;
         pnd_lz    <= bus.lz_en_i;
         pend      <= 1'b1;
      end
   end

   // zrun tracks "this digit and everything above it is zero", scanning from the MSD down
   always_comb begin
      zrun = 1'b1;
      dark = '0;
      for (int k = N_DIGITS - 1; k >= 0; k--) begin
         zrun    = zrun & (act_dig[4*k +: 4] == 4'h0);
         dark[k] = act_blank[k] | (act_blink[k] & ~phase) | (act_lz & zrun & (k != 0));
      end
   end

   always_comb begin
      sel      = '0;
      sel[idx] = 1'b1;
   end

   assign cur_digit = act_dig[4*idx +: 4];

   seg7_hex_decode u_dec (
      .hex (cur_digit),
      .seg (dec_seg)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_o   <= SEG_OFF;
         dp_o    <= 1'b1;
         an_o    <= '1;
         frame_o <= 1'b0;
      end else begin
         frame_o <= frame_tick;
         if (cnt < CNT_W'(BLANK_CYCLES)) begin
            seg_o <= SEG_OFF;
            dp_o  <= 1'b1;
            an_o  <= '1;
         end else begin
            an_o  <= ~sel;
            seg_o <= dark[idx] ? SEG_OFF : dec_seg;
            dp_o  <= dark[idx] | ~act_dp[idx];
         end
      end
   end

endmodule
